swap_initiator: RTL
===================

Name: swap_initiator

Overview:
- Host-side controller that drives a swap datapath through its external load/trigger interface: Data, RinExt1..3, w, Done, R1..R3.
- Accepts one host command carrying three operands, loads them into R1/R2/R3, pulses w, and waits for Done.
- Then captures the swapped register contents and returns them to the host with a single-cycle response strobe.
- Sits between a host sequencer and one swap datapath instance; it is the initiating end of the swap protocol.

Parameters:
n, 8, data/register width
TMO, 15, max cycles spent in WAIT before timeout error (must be >= 4)

Ports:
Resetn  in  1  asynchronous, active-low reset
Clock  in  1  clock; all state changes on posedge Clock
start  in  1  host command strobe; sampled only in IDLE
in_a  in  n  operand loaded into R1
in_b  in  n  operand loaded into R2
in_c  in  n  operand loaded into R3
busy  out  1  high whenever state != IDLE
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  valid with rsp_valid; 1 = timeout
out_r1  out  n  captured R1
out_r2  out  n  captured R2
out_r3  out  n  captured R3
Data  out  n  swap datapath data bus input
RinExt1  out  1  external load enable, R1
RinExt2  out  1  external load enable, R2
RinExt3  out  1  external load enable, R3
w  out  1  swap trigger
Done  in  1  swap complete (high during final swap step)
R1  in  n  swap datapath register R1
R2  in  n  swap datapath register R2
R3  in  n  swap datapath register R3

Behaviour:
- Reset: Resetn is asynchronous, active-low; clock is Clock. Reset forces IDLE and clears the operand registers, out_r1..3, rsp_valid, rsp_err and the timeout counter to 0.
- Reset mid-operation: abort immediately; no response is issued.
- States: IDLE, LD1, LD2, LD3, TRIG, WAIT, CAPT.
- IDLE:
  - If start=1, latch in_a/in_b/in_c into the operand registers and go to LD1.
  - If start=0, stay in IDLE.
  - start is ignored in every other state; there is no queueing.
- LD1: Data = op_a, RinExt1 = 1; go to LD2.
- LD2: Data = op_b, RinExt2 = 1; go to LD3.
- LD3: Data = op_c, RinExt3 = 1; go to TRIG.
- TRIG: w = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - w = 0. The counter increments each WAIT cycle.
  - If Done = 1, go to CAPT.
  - Else, if counter == TMO-1, go to IDLE, pulse rsp_valid = 1 with rsp_err = 1, and leave out_r* unchanged.
  - Done and the timeout in the same cycle: Done wins.
- CAPT: at the exit edge, out_r1..3 <= R1..R3, rsp_valid <= 1, rsp_err <= 0; go to IDLE.
- Output decoding:
  - Data, RinExt1..3 and w are decoded combinationally from the state only; they never depend on start or Done.
  - Outside the LD states, Data = 0 and RinExt1..3 = 0.
  - At most one RinExt is high in any cycle.
- rsp_valid is registered and high for exactly one cycle. rsp_err is 0 whenever rsp_valid is 0.
- Nominal latency, counting edge E0 as the edge that samples start in IDLE:
  - E1–E3: loads of R1, R2, R3.
  - E4: swap begins.
  - Done is high between E6 and E7.
  - E8: capture. rsp_valid is high in the cycle after E8.
- busy drops at the same edge rsp_valid rises. A new start in that same cycle is accepted.
- Expected data for a correct datapath: out_r1 = in_b, out_r2 = in_a, out_r3 = in_b.

Decomposition:
- Shared package: state encoding constants (IDLE..CAPT, 3 bits) and the default TMO value.
- One sub-module, swap_tmo_cnt: clear/enable counter with terminal-count output at TMO-1, parameterised by TMO.
- FSM, operand/result registers and output decode stay in swap_initiator.

Test Plan:
- Nominal swap: start with a=8'h11, b=8'h22, c=8'h33 against a real swap datapath -> rsp_valid 8 edges after the sampling edge; out_r1=8'h22, out_r2=8'h11, out_r3=8'h22, rsp_err=0; w high exactly one cycle.
- Load sequencing: same command -> RinExt1/2/3 high in consecutive cycles with Data 8'h11/8'h22/8'h33; Data=0 and no RinExt otherwise.
- Timeout: Done tied 0, start with any values -> rsp_valid=1, rsp_err=1 exactly TMO WAIT cycles after TRIG; out_r* keep prior values; busy=0 afterwards.
- start while busy: second start pulses during LD2 and WAIT -> ignored, operands unchanged, exactly one response; back-to-back start in the rsp_valid cycle -> accepted, second response correct.
- Reset mid-operation: assert Resetn=0 during WAIT -> all outputs 0 asynchronously, no rsp_valid; after release, a fresh command (a=8'hA5, b=8'h5A) completes normally.
- Done/timeout collision with TMO=4 and a model asserting Done on the last allowed WAIT cycle -> capture path taken, rsp_err=0.

Source files
------------

// File: rtl/swap_initiator_pkg.sv
// Shared definitions for the swap initiator slice.
// Contents: FSM state encoding (3 bits), default width and timeout constants,
// and a helper that maps a load state onto the RinExt1..3 enables.
package swap_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD1  = 3'd1,
        ST_LD2  = 3'd2,
        ST_LD3  = 3'd3,
        ST_TRIG = 3'd4,
        ST_WAIT = 3'd5,
        ST_CAPT = 3'd6
    } state_e;

    localparam int DEFAULT_N   = 8;
    localparam int DEFAULT_TMO = 15;

    // Bit 0 drives RinExt1, bit 1 RinExt2, bit 2 RinExt3; never more than one set.
    function automatic logic [2:0] ld_enables(input state_e st);
        logic [2:0] en;
        case (st)
            ST_LD1:  en = 3'b001;
            ST_LD2:  en = 3'b010;
            ST_LD3:  en = 3'b100;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/swap_initiator_if.sv
// Load/trigger bus between the swap initiator and one swap datapath.
// Signals:
//   Data     initiator -> datapath  operand being loaded
//   RinExt1..3 initiator -> datapath  per-register load enables
//   w        initiator -> datapath  swap trigger
//   Done     datapath -> initiator  high during the final swap step
//   R1..R3   datapath -> initiator  current register contents
// Modports: master = initiator side, slave = datapath side.
interface swap_initiator_if #(
    parameter int n = 8
) ();

    logic [n-1:0] Data;
    logic         RinExt1;
    logic         RinExt2;
    logic         RinExt3;
    logic         w;
    logic         Done;
    logic [n-1:0] R1;
    logic [n-1:0] R2;
    logic [n-1:0] R3;

    modport master (
        output Data, RinExt1, RinExt2, RinExt3, w,
        input  Done, R1, R2, R3
    );

    modport slave (
        input  Data, RinExt1, RinExt2, RinExt3, w,
        output Done, R1, R2, R3
    );

endinterface

// File: rtl/swap_initiator_tmo_cnt.sv
// Module swap_tmo_cnt: WAIT-state timeout counter.
// Ports:
//   Clock, Resetn  clock and asynchronous active-low reset
//   clr_i          synchronous clear (takes priority over en_i)
//   en_i           count enable, one increment per enabled cycle
//   tc_o           high while the count equals TMO-1
// The count saturates at TMO-1 so it can never wrap back below the terminal value.
module swap_tmo_cnt #(
    parameter int TMO = 15
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            CW     = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TMO - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/swap_initiator.sv
// Host-side swap initiator. Takes one command (three operands), loads them into
// the datapath's R1/R2/R3 on consecutive cycles, pulses w, waits for Done (or a
// timeout), then returns the captured registers with a one-cycle rsp_valid.
// Host ports:
//   start        command strobe, sampled only when idle
//   in_a/b/c     operands for R1/R2/R3
//   busy         high whenever a command is in progress
//   rsp_valid    one-cycle response strobe
//   rsp_err      1 = timeout (only meaningful with rsp_valid)
//   out_r1..3    captured R1..R3 (unchanged by a timeout)
// Datapath side: bus (swap_initiator_if.master).
module swap_initiator
    import swap_initiator_pkg::*;
#(
    parameter int n   = DEFAULT_N,
    parameter int TMO = DEFAULT_TMO
) (
    input  logic             Resetn,
    input  logic             Clock,
    input  logic             start,
    input  logic [n-1:0]     in_a,
    input  logic [n-1:0]     in_b,
    input  logic [n-1:0]     in_c,
    output logic             busy,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [n-1:0]     out_r1,
    output logic [n-1:0]     out_r2,
    output logic [n-1:0]     out_r3,
    swap_initiator_if.master bus
);

    state_e       state_q;
    logic [n-1:0] op_a_q;
    logic [n-1:0] op_b_q;
    logic [n-1:0] op_c_q;
    logic [n-1:0] out_r1_q;
    logic [n-1:0] out_r2_q;
    logic [n-1:0] out_r3_q;
    logic         rsp_valid_q;
    logic         rsp_err_q;

    logic         tmo_tc_s;
    logic [n-1:0] data_s;
    logic [2:0]   rin_s;
    logic         w_s;

    swap_tmo_cnt #(
        .TMO (TMO)
    ) u_tmo_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr_i  (state_q == ST_TRIG),
        .en_i   (state_q == ST_WAIT),
        .tc_o   (tmo_tc_s)
    );

    // Sequencer: state, operand latch, result capture and response strobe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            op_a_q      <= {n{1'b0}};
            op_b_q      <= {n{1'b0}};
            op_c_q      <= {n{1'b0}};
            out_r1_q    <= {n{1'b0}};
            out_r2_q    <= {n{1'b0}};
            out_r3_q    <= {n{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // The response strobe lasts one cycle unless re-raised below.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_a_q  <= in_a;
                        op_b_q  <= in_b;
                        op_c_q  <= in_c;
                        state_q <= ST_LD1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LD1:  state_q <= ST_LD2;
                ST_LD2:  state_q <= ST_LD3;
                ST_LD3:  state_q <= ST_TRIG;
                ST_TRIG: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (bus.Done) begin
                        state_q <= ST_CAPT;
                    end else if (tmo_tc_s) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_CAPT: begin
                    out_r1_q    <= bus.R1;
                    out_r2_q    <= bus.R2;
                    out_r3_q    <= bus.R3;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Datapath drive decoded from the state alone.
    always_comb begin
        data_s = {n{1'b0}};
        rin_s  = ld_enables(state_q);
        w_s    = 1'b0;
        case (state_q)
            ST_LD1:  data_s = op_a_q;
            ST_LD2:  data_s = op_b_q;
            ST_LD3:  data_s = op_c_q;
            ST_TRIG: w_s    = 1'b1;
            default: begin
                data_s = {n{1'b0}};
                w_s    = 1'b0;
            end
        endcase
    end

    assign bus.Data    = data_s;
    assign bus.RinExt1 = rin_s[0];
    assign bus.RinExt2 = rin_s[1];
    assign bus.RinExt3 = rin_s[2];
    assign bus.w       = w_s;

    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign out_r1    = out_r1_q;
    assign out_r2    = out_r2_q;
    assign out_r3    = out_r3_q;

endmodule
